// File: rtl/data_mem_unit.sv
// data_mem_unit: word-organised data memory with byte/half/word loads and
// stores, driven by a small IDLE/RD/WR/DONE controller. Sub-word stores are
// done as read-modify-write. Optional feature macro: DMEM_ALIGN_TRAP_EN
// (misaligned or invalid accesses fault instead of being silently aligned).
module data_mem_unit #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  memop,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t            r_state;
  size_t             r_size;
  logic              r_uns;
  logic              r_we;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_lane;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;
  logic              r_ready;
  logic              r_busy;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_W-1:0] w_in_idx;
  size_t             w_size;
  logic              w_uns;
  logic              w_bad_op;
  logic              w_fault;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;
  logic              w_unused_hi;

  // Upper address bits wrap: only the word index inside the array matters.
  assign w_in_idx    = addr[ADDR_W+1:2];
  assign w_unused_hi = ^addr[31:ADDR_W+2];

  // Decode memop into access size/signedness and detect faulting requests.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_size   = SZ_W;
    w_uns    = 1'b0;
    w_bad_op = 1'b0;
    w_fault  = 1'b0;
    case (memop)
      3'b000:  w_size = SZ_B;
      3'b001:  w_size = SZ_H;
      3'b010:  w_size = SZ_W;
      3'b100:  begin w_size = SZ_B; w_uns = 1'b1; end
      3'b101:  begin w_size = SZ_H; w_uns = 1'b1; end
      default: w_bad_op = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (we && memop[2]) w_bad_op = 1'b1;
`ifdef DMEM_ALIGN_TRAP_EN
    w_fault = w_bad_op
            || (w_size == SZ_H && addr[0])
            || (w_size == SZ_W && addr[1:0] != 2'b00);
`else
    // Invalid ops degrade to a plain word access; misaligned low bits are
    // simply ignored by the lane selection below.
    if (w_bad_op) begin
      w_size = SZ_W;
      w_uns  = 1'b0;
    end
`endif
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    w_byte   = r_word[{r_lane, 3'b000} +: 8];
    w_half   = r_word[{r_lane[1], 4'b0000} +: 16];
    w_load   = r_word;
    w_merged = r_word;
    case (r_size)
      SZ_B: begin
        w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
        w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      end
      SZ_H: begin
        w_load = {{16{~r_uns & w_half[15]}}, w_half};
        w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: begin
        w_load   = r_word;
        w_merged = r_wdata;
      end
    endcase
  end

  // Storage: write at the end of WR (unless reset), registered read on accept.
  always_ff @(posedge clk) begin
    // NOTE: the array itself is never reset, so its contents survive rst and it maps to block RAM.
    if (!rst && r_state == WR) r_mem[r_idx] <= w_merged;
    if (r_state == IDLE && req) r_word <= r_mem[w_in_idx];
  end

  // Controller with registered handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
          if (req) begin
            r_we    <= we;
            r_idx   <= w_in_idx;
            r_lane  <= addr[1:0];
            r_wdata <= wdata;
            r_size  <= w_size;
            r_uns   <= w_uns;
            r_busy  <= 1'b1;
            if (w_fault) begin
              r_state <= DONE;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
            end else if (we && w_size == SZ_W) begin
              r_state <= WR;
            end else begin
              r_state <= RD;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        RD: begin
          if (r_we) begin
            r_state <= WR;
          end else begin
            r_state <= DONE;
            r_ready <= 1'b1;
            r_rdata <= w_load;
          end
        end
        WR: begin
          r_state <= DONE;
          r_ready <= 1'b1;
          r_rdata <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, word-index width (memory holds 2^ADDR_W 32-bit words).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port req  input  1  access request, sampled only in IDLE.
REQ-005 SHALL provide port we  input  1  1 = store, 0 = load.
REQ-006 SHALL provide port addr  input  32  byte address.
REQ-007 SHALL provide port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 SHALL provide port memop  input  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; others invalid.
REQ-009 SHALL provide port rdata  output  32  load result, extended per memop, valid while ready=1.
REQ-010 SHALL provide port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-012 SHALL provide port err  output  1  access fault flag, valid while ready=1.

Function
REQ-013 SHALL implement FSM states IDLE, RD, WR, DONE.
REQ-014 SHALL latch we, addr, wdata, memop on a cycle where state=IDLE and req=1; inputs are ignored in all other states.
REQ-015 SHALL index memory with addr[ADDR_W+1:2]; upper address bits ignored (wrap modulo 2^ADDR_W words).
REQ-016 Load: IDLE -> RD (synchronous word read) -> DONE -> IDLE; ready at cycle N+2 for req at N.
REQ-017 Word store (memop 010): IDLE -> WR (full word written at end of WR) -> DONE -> IDLE; ready at N+2.
REQ-018 Sub-word store (000, 001): IDLE -> RD -> WR (read-modify-write, only addressed lanes replaced) -> DONE -> IDLE; ready at N+3.
REQ-019 Byte lane = addr[1:0]; half lane = addr[1] (bytes [15:0] or [31:16]).
REQ-020 lb/lh SHALL sign-extend, lbu/lhu SHALL zero-extend, lw SHALL pass the word unchanged.
REQ-021 ready SHALL be 1 only in DONE; rdata SHALL be 0 in DONE for stores and faulted accesses.
REQ-022 A req asserted during busy=1 SHALL be dropped, not queued; a req in the IDLE cycle after DONE SHALL be accepted.
REQ-023 Faulted access (per REQ-030) SHALL go IDLE -> DONE with err=1, ready at N+1, no memory write.
REQ-024 Load of a word stored earlier SHALL return the stored value (no stale data; RAM write completes before the next RD).

Reset
REQ-025 rst=1 at a rising edge SHALL force state=IDLE, ready=0, busy=0, err=0, rdata=0.
REQ-026 Reset during RD or WR SHALL abort the access; reset asserted in the WR cycle SHALL suppress the write.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 rst SHALL take priority over a simultaneous req.

Configuration
REQ-029 SHALL support macro DMEM_ALIGN_TRAP_EN.
REQ-030 With DMEM_ALIGN_TRAP_EN defined: half access with addr[0]=1, word access with addr[1:0]!=0, or invalid memop (011, 110, 111, store with 100/101) SHALL fault per REQ-023.
REQ-031 Without DMEM_ALIGN_TRAP_EN: misaligned accesses proceed with offending low address bits forced to 0; invalid memop treated as lw/sw; err SHALL be constant 0.

Verification
REQ-032 sw addr=0x40 wdata=0xDEADBEEF, then lw addr=0x40 -> rdata=0xDEADBEEF, ready at N+2 for each access.
REQ-033 Over word 0x11223344 at 0x80: sb addr=0x81 wdata=0xAA (ready at N+3), then lw 0x80 -> 0x1122AA44; lb 0x81 -> 0xFFFFFFAA; lbu 0x81 -> 0x000000AA.
REQ-034 Word 0x80001234 at 0x10: lh 0x12 -> 0xFFFF8000; lhu 0x10 -> 0x00001234.
REQ-035 With DMEM_ALIGN_TRAP_EN: lw addr=0x42 -> ready at N+1, err=1, rdata=0; without macro: same access returns word at 0x40, err=0.
REQ-036 sw 0x20 wdata=0x55 with rst=1 in WR cycle, then lw 0x20 -> prior contents; req held during busy issues exactly one access.
